// File: rtl/cpu_defs_pkg.sv
// rtl/cpu_defs_pkg.sv - opcodes, IR field positions and fetch FSM encoding
package cpu_defs_pkg;

    localparam logic [5:0] OP_ALU = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] OP_JMP = 6'b000010;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;
    localparam int FUNC_MSB   = 10;
    localparam int FUNC_LSB   = 0;
    localparam int JTGT_MSB   = 25;
    localparam int JTGT_LSB   = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_next_pc.sv
// rtl/fetch_next_pc.sv - combinational next-PC select: sequential, BNE target or JMP target
module fetch_next_pc
    import cpu_defs_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [31:0]       ir,
    input  logic              pc_select_enable,
    output logic [ADDR_W-1:0] next_pc
);

    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] branch_offset;
    logic [ADDR_W-1:0] jump_target;

    assign pc_plus4      = pc + ADDR_W'(4);
    assign branch_offset = {{(ADDR_W-18){ir[IMM_MSB]}}, ir[IMM_MSB:IMM_LSB], 2'b00};
    // Jump keeps the top nibble of the sequential PC, so it stays in the current 256MB region.
    assign jump_target   = {pc_plus4[ADDR_W-1:28], ir[JTGT_MSB:JTGT_LSB], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (pc_select_enable) begin
            if (ir[OPCODE_MSB:OPCODE_LSB] == OP_JMP)
                next_pc = jump_target;
            else
                next_pc = pc_plus4 + branch_offset;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC/NPC/IR holding fetch stage with ready-based imem handshake
module instr_fetch_unit
    import cpu_defs_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pc_enable,
    input  logic              pc_select_enable,
    input  logic              npc_enable,
    input  logic              ir_enable,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ready,
    output logic [31:0]       ir,
    output logic [5:0]        opcode,
    output logic [10:0]       alu_func,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [15:0]       imm16,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] npc,
    output logic              ir_valid,
    output logic              protocol_err,
    output logic [31:0]       instr_count
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] next_pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic              any_strobe;

    fetch_next_pc #(.ADDR_W(ADDR_W)) u_next_pc (
        .pc               (pc),
        .ir               (ir),
        .pc_select_enable (pc_select_enable),
        .next_pc          (next_pc)
    );

    assign pc_plus4   = pc + ADDR_W'(4);
    assign any_strobe = pc_enable | pc_select_enable | npc_enable | ir_enable;

    assign opcode   = ir[OPCODE_MSB:OPCODE_LSB];
    assign rs       = ir[RS_MSB:RS_LSB];
    assign rt       = ir[RT_MSB:RT_LSB];
    assign rd       = ir[RD_MSB:RD_LSB];
    assign imm16    = ir[IMM_MSB:IMM_LSB];
    assign alu_func = ir[FUNC_MSB:FUNC_LSB];

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            pc           <= RESET_PC;
            npc          <= RESET_PC + ADDR_W'(4);
            ir           <= '0;
            ir_valid     <= 1'b0;
            imem_req     <= 1'b0;
            imem_addr    <= RESET_PC;
            protocol_err <= 1'b0;
            instr_count  <= '0;
        end else begin
            // The CU must only act on an instruction that is actually held in IR.
            if (any_strobe && !ir_valid)
                protocol_err <= 1'b1;

            case (state)
                ST_IDLE: begin
                    imem_req  <= 1'b1;
                    imem_addr <= pc;
                    state     <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (imem_ready) begin
                        ir       <= imem_rdata;
                        ir_valid <= 1'b1;
                        imem_req <= 1'b0;
                        state    <= ST_VALID;
                    end
                end
                ST_VALID: begin
                    if (pc_enable && ir_enable) begin
                        pc          <= next_pc;
                        if (npc_enable)
                            npc <= pc_plus4;
                        instr_count <= instr_count + 32'd1;
                        ir_valid    <= 1'b0;
                        imem_req    <= 1'b1;
                        imem_addr   <= next_pc;
                        state       <= ST_FETCH;
                    end else if (pc_enable) begin
                        pc <= next_pc;
                    end else if (ir_enable) begin
                        ir_valid  <= 1'b0;
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                        state     <= ST_FETCH;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch and instruction-register stage sitting directly upstream of the multi-cycle control unit (CU). It holds PC, NPC and IR, and fetches from instruction memory over a ready-based handshake. It decodes fields for the CU (opcode, ALU func) and the datapath (rs, rt, rd, imm16). It applies the CU's pc_enable, pc_select_enable, npc_enable and ir_enable strobes to retire an instruction and compute the next PC (sequential, BNE-taken, or JMP).

Parameters:
RESET_PC, 32'h0000_0000, PC after reset; must be word aligned.
ADDR_W, 32, width of PC, NPC and imem_addr.

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high; sampled on rising edge of clk
pc_enable  in  1  CU strobe: update PC this cycle
pc_select_enable  in  1  CU strobe: 1 = take branch/jump target, 0 = PC+4
npc_enable  in  1  CU strobe: load NPC with PC+4 on retire
ir_enable  in  1  CU strobe: fetch new instruction into IR
imem_req  out  1  instruction-memory request, registered
imem_addr  out  ADDR_W  request address, registered, stable while imem_req=1
imem_rdata  in  32  instruction word, valid when imem_ready=1
imem_ready  in  1  memory response strobe; sampled only while imem_req=1
ir  out  32  instruction register
opcode  out  6  ir[31:26]
alu_func  out  11  ir[10:0]
rs, rt, rd  out  5 each  ir[25:21], ir[20:16], ir[15:11]
imm16  out  16  ir[15:0]
pc  out  ADDR_W  current PC
npc  out  ADDR_W  NPC register
ir_valid  out  1  IR holds a fetched, unretired instruction
protocol_err  out  1  sticky; set on a CU strobe while ir_valid=0
instr_count  out  32  retired-instruction counter

Behaviour:
- Reset values:
  - pc=RESET_PC, npc=RESET_PC+4, ir=0, ir_valid=0.
  - imem_req=0, imem_addr=RESET_PC.
  - protocol_err=0, instr_count=0, state=IDLE.
- Reset has priority over everything. Asserted mid-fetch, it drops imem_req the next edge, and any later imem_ready is ignored.
- FSM states: IDLE, FETCH, VALID.
  - IDLE: lasts 1 cycle after reset release. Sets imem_req=1 and imem_addr=pc, then goes to FETCH.
  - FETCH: imem_req=1. On imem_ready=1: ir<=imem_rdata, ir_valid<=1, imem_req<=0, go to VALID.
    - Ready may arrive in the first FETCH cycle, giving minimum latency of 1 cycle from req to IR load.
    - CU strobes arriving in FETCH are ignored and set protocol_err.
  - VALID: waits for CU strobes. Outcome by pc_enable / ir_enable:
    - 1/1 (normal retire): pc<=next_pc; npc<=pc+4 if npc_enable; instr_count+=1 (wraps at 2^32); ir_valid<=0; imem_req<=1, imem_addr<=next_pc; go to FETCH.
    - 1/0: pc<=next_pc only; IR retained; stay in VALID. No count increment.
    - 0/1: refetch current pc (ir_valid<=0, imem_req<=1, imem_addr<=pc); go to FETCH. No count increment.
    - 0/0: hold.
- next_pc is computed from the current ir:
  - pc_select_enable=0: pc+4.
  - pc_select_enable=1 and opcode=6'b000010 (JMP): {pc_plus4[31:28], ir[25:0], 2'b00}.
  - pc_select_enable=1 and any other opcode (BNE): pc+4 + (sign-extended imm16 << 2).
- All additions are modulo 2^ADDR_W; wrap at 32'hFFFF_FFFC → 0 is legal.
- Decoded field outputs are combinational from ir. All other outputs are registered.
- imem_rdata is ignored whenever imem_req=0.

Decomposition:
- Package cpu_defs_pkg holds:
  - opcode constants OP_ALU=000000, OP_LW=100011, OP_SW=101011, OP_BNE=000101, OP_JMP=000010;
  - IR field bit positions;
  - fetch FSM state encoding.
- Sub-module fetch_next_pc (combinational): inputs pc, ir, pc_select_enable; output next_pc.

Test Plan:
1. Reset release, RESET_PC=0, ready after 3 cycles with rdata=32'h8C22_0004 → imem_req high 3 cycles at addr 0; ir=32'h8C22_0004, opcode=100011, rt=2, ir_valid=1; instr_count=0.
2. In VALID with pc=0x10, assert pc_enable=ir_enable=npc_enable=1, pc_select_enable=0 → pc=0x14, npc=0x14, imem_addr=0x14, instr_count+1.
3. BNE ir=32'h1422_FFFE at pc=0x20, pc_select_enable=1 → next pc=0x1C. JMP ir=32'h0800_0040 at pc=0x20 → next pc=0x100.
4. Strobe during FETCH → ignored, protocol_err=1 and remains 1 until reset; pc unchanged.
5. Reset asserted while imem_req=1, then imem_ready pulsed → ir stays 0, ir_valid=0, pc=RESET_PC; fetch restarts 1 cycle after release.
6. pc=32'hFFFF_FFFC sequential retire → pc=0, no error. Ready in the first FETCH cycle → IR loaded on the next edge.
